xtea_ctr_driver: RTL and testbench
==================================

Name: xtea_ctr_driver

Overview:
- Bus-master sequencer that sits directly upstream of the xtea register-mapped wrapper and drives its cs/we/address/write_data port.
- Runs the cipher in CTR mode over a valid/ready stream of 64-bit blocks: keystream = XTEA(nonce || counter), out = in XOR keystream.
- Loads the key and config once per start, then per block writes BLOCK0/1, pulses CTRL.next, polls STATUS, reads RESULT0/1.

Parameters:
- POLL_TIMEOUT, 255: maximum STATUS polls per wait before the error flag is set.
- KEY_ADDR_BASE, 8'h10: address of KEY0. KEY1..KEY3 follow at +1..+3.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a session. Ignored while busy=1.
- key  in  128  key, sampled at start. key[127:96] goes to KEY0.
- nonce  in  32  sampled at start, written to BLOCK0.
- ctr_init  in  32  initial counter, sampled at start, written to BLOCK1.
- in_valid / in_ready  in/out  1/1  input block handshake.
- in_data  in  64  input block.
- in_last  in  1  marks the final block of the session.
- out_valid / out_ready  out/in  1/1  output block handshake.
- out_data  out  64  in_data XOR keystream.
- out_last  out  1  registered copy of in_last.
- busy  out  1  high whenever the FSM is not in IDLE.
- error  out  1  sticky timeout (and wrap) flag. Cleared by start.
- xtea_cs, xtea_we  out  1/1  bus strobes.
- xtea_address  out  8  bus address.
- xtea_write_data  out  32  bus write data.
- xtea_read_data  in  32  bus read data, combinational. Valid in the same cycle as cs=1, we=0.

Behaviour:
- Reset: all outputs 0 except in_ready=0. State=IDLE, counter=0, poll count=0. A reset mid-operation abandons the session; the bus strobes drop in the next cycle.
- Bus: at most one access per cycle. Every bus output is a register. Read data is captured at the end of the cycle that issues the read. The driver never writes ROUNDS, so the wrapper default of 32 applies.
- FSM states and transitions:
  - IDLE: on start, latch key/nonce/ctr_init, clear error, go to PRE_POLL.
  - PRE_POLL: read 8'h09. Bit0=1 goes to KEY.
  - KEY: four consecutive writes, 0x10..0x13 = key[127:96], [95:64], [63:32], [31:0].
  - CFG: write 8'h0a = 32'h1 (encipher).
  - WAIT_IN: in_ready=1. On in_valid, capture in_data/in_last and go to BLK0. in_ready drops in the following cycle.
  - BLK0: write 8'h20 = nonce.
  - BLK1: write 8'h21 = counter.
  - NEXT: write 8'h08 = 32'h2.
  - GAP: one idle cycle so the core deasserts ready.
  - POLL: read 8'h09 every cycle until bit0=1.
  - RD0: read 8'h30 into ks[63:32].
  - RD1: read 8'h31 into ks[31:0].
  - OUT: out_valid=1 holding out_data and out_last until out_ready. On the handshake the counter increments; go to WAIT_IN, or to IDLE if last.
- Counter: 32-bit modulo 2^32. 32'hFFFFFFFF wraps to 0 silently unless the optional feature is enabled.
- Timeout: if PRE_POLL or POLL reaches POLL_TIMEOUT reads without ready, set error=1 and go to IDLE. No output is produced for that block.
- Poll counter resets on entry to each poll state.
- Minimum block period with immediate handshakes: 8 cycles plus the poll count.
- Backpressure: out_valid/out_data are held stable while out_ready=0.
- start while busy: ignored, no effect on latched values.
- A start in the same cycle as the session returns to IDLE is ignored. IDLE must be observed for one cycle first.

Optional Feature:
- Macro XTEA_CTR_WRAP_CHECK_EN.
- Defined: if the counter would increment from 32'hFFFFFFFF, set error=1 and go to IDLE after the current OUT handshake completes.
- Undefined: the counter wraps silently and error is driven only by timeout.

Decomposition:
- Package xtea_pkg holds:
  - the address localparams (NAME0..RESULT1);
  - the CTRL_NEXT_BIT, STATUS_READY_BIT and CONFIG_ENCDEC_BIT constants;
  - a typedef enum for the driver FSM states;
  - typedef ks_t (64-bit).
- No sub-module; the block is a single FSM plus datapath registers.

Test Plan:
- Known vector: start with key=128'h000102030405060708090a0b0c0d0e0f, nonce=32'h41424344, ctr_init=32'h45464748, one block in_data=0, in_last=1 -> out_data=64'h497df3d072612cb5, out_last=1, busy returns to 0.
- Bus sequence for that run (bench model of the wrapper): writes 0x10..0x13 with 00010203, 04050607, 08090a0b, 0c0d0e0f; 0x0a=1; 0x20=41424344; 0x21=45464748; 0x08=2. Then reads of 0x09, 0x30, 0x31 in that order.
- Stream of 3 blocks, ctr_init=5: BLOCK1 writes are 5, 6, 7. Each out_data = in_data XOR model(nonce, ctr). out_ready held low 10 cycles on block 2 -> data stable, no extra bus activity.
- Model ready held low forever after NEXT -> error=1 after POLL_TIMEOUT=255 polls, busy=0, out_valid never asserted. A new start clears error.
- ctr_init=32'hFFFFFFFF, 2 blocks -> second BLOCK1 write is 0 and error=0; with XTEA_CTR_WRAP_CHECK_EN, error=1 after block 1 and no second in_ready.
- reset=1 asserted during POLL -> next cycle xtea_cs=0, busy=0, out_valid=0. start pulses while busy=1 -> latched nonce unchanged.

Source files
------------

// File: rtl/xtea_pkg.sv
// Shared definitions for the xtea CTR-mode bus driver: wrapper register map,
// control/status bit positions, driver FSM states and the keystream type.
package xtea_pkg;

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_NAME1   = 8'h01;
  localparam logic [7:0] ADDR_VERSION = 8'h02;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
  localparam logic [7:0] ADDR_KEY0    = 8'h10;
  localparam logic [7:0] ADDR_KEY1    = 8'h11;
  localparam logic [7:0] ADDR_KEY2    = 8'h12;
  localparam logic [7:0] ADDR_KEY3    = 8'h13;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
  localparam logic [7:0] ADDR_BLOCK1  = 8'h21;
  localparam logic [7:0] ADDR_RESULT0 = 8'h30;
  localparam logic [7:0] ADDR_RESULT1 = 8'h31;

  localparam int unsigned CTRL_NEXT_BIT     = 1;
  localparam int unsigned STATUS_READY_BIT  = 0;
  localparam int unsigned CONFIG_ENCDEC_BIT = 0;

  typedef enum logic [3:0] {
    StIdle,
    StPrePoll,
    StKey,
    StCfg,
    StWaitIn,
    StBlk0,
    StBlk1,
    StNext,
    StGap,
    StPoll,
    StRd0,
    StRd1,
    StOut
  } drv_state_e;

  typedef logic [63:0] ks_t;

  // Word 0 is the most significant 32 bits of the key.
  function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = key[127:96];
      2'd1:    w = key[95:64];
      2'd2:    w = key[63:32];
      default: w = key[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/xtea_ctr_driver.sv
// CTR-mode sequencer driving the xtea register wrapper: out = in ^ XTEA(nonce || counter).
// Optional macro XTEA_CTR_WRAP_CHECK_EN flags counter wrap as an error instead of wrapping.
module xtea_ctr_driver
  import xtea_pkg::*;
#(
  parameter int unsigned POLL_TIMEOUT  = 255,
  parameter logic [7:0]  KEY_ADDR_BASE = 8'h10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [31:0]  nonce,
  input  logic [31:0]  ctr_init,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         error,
  output logic         xtea_cs,
  output logic         xtea_we,
  output logic [7:0]   xtea_address,
  output logic [31:0]  xtea_write_data,
  input  logic [31:0]  xtea_read_data
);

  localparam int unsigned PollW = (POLL_TIMEOUT > 2) ? $clog2(POLL_TIMEOUT) : 1;

`ifdef XTEA_CTR_WRAP_CHECK_EN
  localparam bit WrapCheck = 1'b1;
`else
  localparam bit WrapCheck = 1'b0;
`endif

  drv_state_e   state_q, state_d;
  logic [1:0]   key_idx_q, key_idx_d;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  nonce_q, nonce_d;
  logic [31:0]  ctr_q, ctr_d;
  logic [63:0]  in_data_q, in_data_d;
  logic         in_last_q, in_last_d;
  logic [31:0]  ks_hi_q, ks_hi_d;
  logic         error_q, error_d;

  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [63:0]  out_data_q, out_data_d;
  logic         out_last_q, out_last_d;
  logic         busy_q, busy_d;
  logic         cs_q, cs_d;
  logic         we_q, we_d;
  logic [7:0]   addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;

  logic         status_ready;
  logic         poll_expired;
  ks_t          ks;

  assign status_ready = xtea_read_data[STATUS_READY_BIT];
  assign poll_expired = (poll_cnt_q == PollW'(POLL_TIMEOUT - 1));
  assign ks           = {ks_hi_q, xtea_read_data};

  always_comb begin
    state_d    = state_q;
    key_idx_d  = key_idx_q;
    poll_cnt_d = poll_cnt_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ctr_d      = ctr_q;
    in_data_d  = in_data_q;
    in_last_d  = in_last_q;
    ks_hi_d    = ks_hi_q;
    error_d    = error_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          key_d      = key;
          nonce_d    = nonce;
          ctr_d      = ctr_init;
          error_d    = 1'b0;
          poll_cnt_d = '0;
          state_d    = StPrePoll;
        end
      end
      StPrePoll, StPoll: begin
        if (status_ready) begin
          key_idx_d = '0;
          state_d   = (state_q == StPrePoll) ? StKey : StRd0;
        end else if (poll_expired) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      StKey: begin
        key_idx_d = key_idx_q + 2'd1;
        if (key_idx_q == 2'd3) state_d = StCfg;
      end
      StCfg: state_d = StWaitIn;
      StWaitIn: begin
        if (in_valid) begin
          in_data_d = in_data;
          in_last_d = in_last;
          state_d   = StBlk0;
        end
      end
      StBlk0: state_d = StBlk1;
      StBlk1: state_d = StNext;
      StNext: state_d = StGap;
      StGap: begin
        poll_cnt_d = '0;
        state_d    = StPoll;
      end
      StRd0: begin
        ks_hi_d = xtea_read_data;
        state_d = StRd1;
      end
      StRd1: begin
        out_data_d = in_data_q ^ ks;
        out_last_d = in_last_q;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) begin
          ctr_d = ctr_q + 32'd1;
          if (WrapCheck && (ctr_q == 32'hFFFF_FFFF)) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = in_last_q ? StIdle : StWaitIn;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are registered from the next state so each access lines up with its state.
  always_comb begin
    cs_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = 8'h00;
    wdata_d     = 32'h0;
    in_ready_d  = (state_d == StWaitIn);
    out_valid_d = (state_d == StOut);
    busy_d      = (state_d != StIdle);

    case (state_d)
      StPrePoll, StPoll: begin
        cs_d   = 1'b1;
        addr_d = ADDR_STATUS;
      end
      StKey: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = KEY_ADDR_BASE + {6'd0, key_idx_d};
        wdata_d = key_word(key_q, key_idx_d);
      end
      StCfg: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CONFIG;
        wdata_d = 32'd1 << CONFIG_ENCDEC_BIT;
      end
      StBlk0: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_BLOCK0;
        wdata_d = nonce_q;
      end
      StBlk1: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_BLOCK1;
        wdata_d = ctr_q;
      end
      StNext: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = 32'd1 << CTRL_NEXT_BIT;
      end
      StRd0: begin
        cs_d   = 1'b1;
        addr_d = ADDR_RESULT0;
      end
      StRd1: begin
        cs_d   = 1'b1;
        addr_d = ADDR_RESULT1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      key_idx_q   <= '0;
      poll_cnt_q  <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      in_data_q   <= '0;
      in_last_q   <= 1'b0;
      ks_hi_q     <= '0;
      error_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      key_idx_q   <= key_idx_d;
      poll_cnt_q  <= poll_cnt_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      in_data_q   <= in_data_d;
      in_last_q   <= in_last_d;
      ks_hi_q     <= ks_hi_d;
      error_q     <= error_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_last        = out_last_q;
  assign busy            = busy_q;
  assign error           = error_q;
  assign xtea_cs         = cs_q;
  assign xtea_we         = we_q;
  assign xtea_address    = addr_q;
  assign xtea_write_data = wdata_q;

endmodule

// File: tb/tb_xtea_ctr_driver.sv
// Scoreboard bench for xtea_ctr_driver with a behavioural model of the xtea register wrapper.
module tb_xtea_ctr_driver;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [127:0] key;
  logic [31:0]  nonce, ctr_init;
  logic         in_valid, in_ready, in_last;
  logic [63:0]  in_data;
  logic         out_valid, out_ready, out_last;
  logic [63:0]  out_data;
  logic         busy, error;
  logic         xtea_cs, xtea_we;
  logic [7:0]   xtea_address;
  logic [31:0]  xtea_write_data, xtea_read_data;

  int checks = 0;
  int failures = 0;

  xtea_ctr_driver dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .key            (key),
    .nonce          (nonce),
    .ctr_init       (ctr_init),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .error          (error),
    .xtea_cs        (xtea_cs),
    .xtea_we        (xtea_we),
    .xtea_address   (xtea_address),
    .xtea_write_data(xtea_write_data),
    .xtea_read_data (xtea_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference XTEA encipher, 32 rounds, big-endian word order.
  function automatic logic [63:0] xtea_enc(input logic [127:0] k, input logic [63:0] blk);
    logic [31:0] v0, v1, sum;
    logic [31:0] kw [4];
    v0 = blk[63:32];
    v1 = blk[31:0];
    sum = 32'h0;
    kw[0] = k[127:96]; kw[1] = k[95:64]; kw[2] = k[63:32]; kw[3] = k[31:0];
    for (int r = 0; r < 32; r++) begin
      v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
      sum = sum + 32'h9E3779B9;
      v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
    end
    return {v0, v1};
  endfunction

  // ---------------- wrapper model ----------------
  typedef struct packed {
    logic        we;
    logic [7:0]  a;
    logic [31:0] d;
  } bus_t;

  bus_t        blog[$];
  logic [31:0] mkey [4];
  logic [31:0] mblk0 = 32'h0, mblk1 = 32'h0;
  logic        mready = 1'b1;
  logic [63:0] mres = 64'h0;
  int          lat = 0;
  bit          hang = 1'b0;

  always_comb begin
    xtea_read_data = 32'h0;
    if (xtea_cs && !xtea_we) begin
      case (xtea_address)
        8'h09:   xtea_read_data = {31'h0, mready};
        8'h30:   xtea_read_data = mres[63:32];
        8'h31:   xtea_read_data = mres[31:0];
        default: xtea_read_data = 32'h0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (xtea_cs) blog.push_back(bus_t'({xtea_we, xtea_address, xtea_we ? xtea_write_data
                                                                       : xtea_read_data}));
    if (xtea_cs && xtea_we) begin
      case (xtea_address)
        8'h10: mkey[0] <= xtea_write_data;
        8'h11: mkey[1] <= xtea_write_data;
        8'h12: mkey[2] <= xtea_write_data;
        8'h13: mkey[3] <= xtea_write_data;
        8'h20: mblk0 <= xtea_write_data;
        8'h21: mblk1 <= xtea_write_data;
        8'h08: if (xtea_write_data[1]) begin
          mready <= 1'b0;
          lat    <= int'($urandom_range(0, 6));
          mres   <= xtea_enc({mkey[0], mkey[1], mkey[2], mkey[3]}, {mblk0, mblk1});
        end
        default: ;
      endcase
    end else if (!mready && !hang) begin
      if (lat > 0) lat <= lat - 1;
      else mready <= 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [63:0] exp_q[$];
  logic        exp_last_q[$];
  bit          saw_ov = 1'b0;
  logic [63:0] mon_d;
  logic        mon_l;

  always @(negedge clk) begin
    if (out_valid) saw_ov = 1'b1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %h expected no output", out_data);
      end else begin
        mon_d = exp_q.pop_front();
        mon_l = exp_last_q.pop_front();
        chk("out_data", out_data, mon_d);
        chk("out_last", 64'(out_last), 64'(mon_l));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic begin_session(input logic [127:0] k, input logic [31:0] n, input logic [31:0] c);
    @(posedge clk);
    #1;
    blog.delete();
    saw_ov = 1'b0;
    key = k; nonce = n; ctr_init = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] d, input bit last, input bit push,
                            input logic [63:0] exp);
    bit ok = 1'b0;
    in_data = d; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      if (push) begin exp_q.push_back(exp); exp_last_q.push_back(last); end
      @(posedge clk);
      #1;
    end else begin
      checks++; failures++;
      $display("FAIL in_handshake: got no in_ready expected in_ready within 600 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("idle_reached", 64'(ok), 64'd1);
  endtask

  task automatic chk_writes(input string nm, input logic [7:0] a, input logic [31:0] exp[$]);
    logic [31:0] got[$];
    foreach (blog[i]) if (blog[i].we && blog[i].a == a) got.push_back(blog[i].d);
    chk({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s_%0d", nm, i), 64'(got[i]), 64'(exp[i]));
  endtask

  function automatic int polls_after_last_write();
    int n = 0;
    for (int i = blog.size() - 1; i >= 0; i--) begin
      if (blog[i].we) break;
      if (blog[i].a == 8'h09) n++;
    end
    return n;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k;
    logic [31:0]  n;
    logic [63:0]  d, hold;
    bus_t         wexp[8];
    bus_t         wgot[$];
    logic [7:0]   rc[$];
    bit           ok;

    reset = 1'b1; start = 1'b0; key = '0; nonce = '0; ctr_init = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 64'({in_ready, out_valid, out_last, busy, error, xtea_cs, xtea_we}), 64'd0);
    chk("reset_bus", 64'({xtea_address, xtea_write_data}), 64'd0);
    chk("reset_out_data", out_data, 64'd0);

    // Known vector
    k = 128'h000102030405060708090a0b0c0d0e0f;
    begin_session(k, 32'h41424344, 32'h45464748);
    send_block(64'h0, 1'b1, 1'b1, 64'h497df3d072612cb5);
    wait_idle(200);
    chk("kv_error", 64'(error), 64'd0);
    wexp[0] = '{1'b1, 8'h10, 32'h00010203};
    wexp[1] = '{1'b1, 8'h11, 32'h04050607};
    wexp[2] = '{1'b1, 8'h12, 32'h08090a0b};
    wexp[3] = '{1'b1, 8'h13, 32'h0c0d0e0f};
    wexp[4] = '{1'b1, 8'h0a, 32'h00000001};
    wexp[5] = '{1'b1, 8'h20, 32'h41424344};
    wexp[6] = '{1'b1, 8'h21, 32'h45464748};
    wexp[7] = '{1'b1, 8'h08, 32'h00000002};
    wgot.delete();
    rc.delete();
    foreach (blog[i]) begin
      if (blog[i].we) wgot.push_back(blog[i]);
      else if (rc.size() == 0 || rc[rc.size() - 1] != blog[i].a) rc.push_back(blog[i].a);
    end
    chk("kv_wr_count", 64'(wgot.size()), 64'd8);
    for (int i = 0; i < 8 && i < wgot.size(); i++)
      chk($sformatf("kv_wr_%0d", i), 64'(wgot[i]), 64'(wexp[i]));
    chk("kv_rd_count", 64'(rc.size()), 64'd3);
    if (rc.size() == 3) chk("kv_rd_order", 64'({rc[0], rc[1], rc[2]}), 64'h093031);

    // Three-block stream with backpressure and an ignored start
    k = {$urandom, $urandom, $urandom, $urandom};
    n = $urandom;
    begin_session(k, n, 32'd5);
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      send_block(d, i == 2, 1'b1, d ^ xtea_enc(k, {n, 32'd5 + 32'(i)}));
      if (i == 0) begin
        start = 1'b1; nonce = ~n; ctr_init = 32'd99;
        @(posedge clk);
        #1 start = 1'b0; nonce = n;
      end
      if (i == 1) begin
        out_ready = 1'b0;
        ok = 1'b0;
        for (int j = 0; j < 600; j++) begin
          @(negedge clk);
          if (out_valid) begin ok = 1'b1; break; end
        end
        chk("bp_out_valid", 64'(ok), 64'd1);
        hold = out_data;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          chk("bp_hold", out_data, hold);
          chk("bp_bus_idle", 64'({out_valid, xtea_cs}), 64'b10);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    end
    wait_idle(300);
    chk_writes("blk1", 8'h21, '{32'd5, 32'd6, 32'd7});
    chk_writes("blk0", 8'h20, '{n, n, n});

    // Poll timeout
    hang = 1'b1;
    begin_session(k, n, 32'd1);
    send_block({$urandom, $urandom}, 1'b1, 1'b0, 64'h0);
    wait_idle(1000);
    chk("to_error", 64'(error), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_no_out", 64'(saw_ov), 64'd0);
    chk("to_poll_count", 64'(polls_after_last_write()), 64'd255);
    hang = 1'b0;
    begin_session(k, n, 32'd9);
    chk("restart_clears_error", 64'(error), 64'd0);
    d = {$urandom, $urandom};
    send_block(d, 1'b1, 1'b1, d ^ xtea_enc(k, {n, 32'd9}));
    wait_idle(300);

    // Counter wrap
    k = {$urandom, $urandom, $urandom, $urandom};
    n = $urandom;
    begin_session(k, n, 32'hFFFF_FFFF);
    d = {$urandom, $urandom};
`ifdef XTEA_CTR_WRAP_CHECK_EN
    send_block(d, 1'b0, 1'b1, d ^ xtea_enc(k, {n, 32'hFFFF_FFFF}));
    wait_idle(300);
    chk("wrap_error", 64'(error), 64'd1);
    repeat (10) @(negedge clk);
    chk("wrap_no_in_ready", 64'(in_ready), 64'd0);
    chk_writes("wrap_blk1", 8'h21, '{32'hFFFF_FFFF});
`else
    send_block(d, 1'b0, 1'b1, d ^ xtea_enc(k, {n, 32'hFFFF_FFFF}));
    d = {$urandom, $urandom};
    send_block(d, 1'b1, 1'b1, d ^ xtea_enc(k, {n, 32'h0}));
    wait_idle(300);
    chk("wrap_error", 64'(error), 64'd0);
    chk_writes("wrap_blk1", 8'h21, '{32'hFFFF_FFFF, 32'h0});
`endif

    // Reset during POLL
    hang = 1'b1;
    begin_session(k, n, 32'd3);
    send_block({$urandom, $urandom}, 1'b1, 1'b0, 64'h0);
    repeat (15) @(negedge clk);
    chk("in_poll", 64'({xtea_cs, xtea_we, xtea_address}), 64'({1'b1, 1'b0, 8'h09}));
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_poll", 64'({xtea_cs, busy, out_valid}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    hang = 1'b0;
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
